// File: rtl/seq_det_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_ctrl_if
// Brief    : Control/config/serial-data bundle for the sequence detector.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_det_ctrl_if #(
    parameter int MAXL = 8,
    parameter int TW   = 8
);
    logic            start;
    logic            abort;
    logic [MAXL-1:0] cfg_pattern;
    logic [2:0]      cfg_len;
    logic [TW-1:0]   cfg_timeout;
    logic            seq_in;
    logic            seq_valid;
    logic            busy;
    logic            done;
    logic            match;
    logic            timeout;
    logic [TW-1:0]   match_pos;
    logic [3:0]      match_cnt;

    modport master (
        output start, abort, cfg_pattern, cfg_len, cfg_timeout, seq_in, seq_valid,
        input  busy, done, match, timeout, match_pos, match_cnt
    );

    modport slave (
        input  start, abort, cfg_pattern, cfg_len, cfg_timeout, seq_in, seq_valid,
        output busy, done, match, timeout, match_pos, match_cnt
    );
endinterface
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_ctrl
// Brief    : Serial pattern detector with timeout budget and session control.
//            SEQ_DET_CTRL_CONT_EN selects continuous (count-all-hits) mode.
// Revision : 1.0 - initial release
// ============================================================================
module seq_det_ctrl #(
    parameter int MAXL = 8,
    parameter int TW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_det_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_cnt_max = 4'hF;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [MAXL-1:0] r_pat;
    logic [MAXL-1:0] r_sh;
    logic [MAXL-1:0] w_sh_nxt;
    logic [MAXL-1:0] w_mask;
    logic [2:0]      r_len;
    logic [TW-1:0]   r_tmo;
    logic [TW-1:0]   r_bits;
    logic [TW-1:0]   w_bits_sat;
    logic [TW-1:0]   r_match_pos;
    logic [TW:0]     w_bits_p1;
    logic [TW:0]     w_len_full;
    logic            r_match;
    logic            r_timeout;
    logic [3:0]      r_match_cnt;
    logic            w_hit;
    logic            w_expire;
    logic            w_accept;
    logic            w_shift_en;

    assign w_sh_nxt   = {r_sh[MAXL-2:0], bus.seq_in};
    assign w_mask     = ~({MAXL{1'b1}} << ({1'b0, r_len} + 4'd1));
    assign w_bits_p1  = {1'b0, r_bits} + (TW+1)'(1);
    assign w_bits_sat = w_bits_p1[TW] ? {TW{1'b1}} : w_bits_p1[TW-1:0];
    assign w_len_full = (TW+1)'(r_len) + (TW+1)'(1);

    // Length gate keeps the zero-cleared shift register from matching early.
    assign w_hit    = (w_bits_p1 >= w_len_full) &&
                      ((w_sh_nxt & w_mask) == (r_pat & w_mask));
    assign w_expire = (r_tmo != '0) && (w_bits_p1 == {1'b0, r_tmo});

    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == DONE);
    assign bus.match     = r_match;
    assign bus.timeout   = r_timeout;
    assign bus.match_pos = r_match_pos;
    assign bus.match_cnt = r_match_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_shift_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                    w_accept    = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    w_state_nxt = IDLE;
                end else if (bus.seq_valid) begin
                    w_shift_en = 1'b1;
`ifdef SEQ_DET_CTRL_CONT_EN
                    if (w_expire) begin
                        w_state_nxt = DONE;
                    end
`else
                    if (w_hit || w_expire) begin
                        w_state_nxt = DONE;
                    end
`endif
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat       <= '0;
            r_len       <= '0;
            r_tmo       <= '0;
            r_sh        <= '0;
            r_bits      <= '0;
            r_match     <= 1'b0;
            r_timeout   <= 1'b0;
            r_match_pos <= '0;
            r_match_cnt <= '0;
        end else if (w_accept) begin
            r_pat       <= bus.cfg_pattern;
            r_len       <= bus.cfg_len;
            r_tmo       <= bus.cfg_timeout;
            r_sh        <= '0;
            r_bits      <= '0;
            r_match     <= 1'b0;
            r_timeout   <= 1'b0;
            r_match_pos <= '0;
            r_match_cnt <= '0;
        end else if (w_shift_en) begin
            r_sh   <= w_sh_nxt;
            r_bits <= w_bits_sat;
            if (w_hit && !r_match) begin
                r_match     <= 1'b1;
                r_match_pos <= w_bits_sat;
            end
`ifdef SEQ_DET_CTRL_CONT_EN
            if (w_hit && (r_match_cnt != c_cnt_max)) begin
                r_match_cnt <= r_match_cnt + 4'd1;
            end
            // A hit on the expiring bit still counts as a match.
            if (w_expire) begin
                r_timeout <= ~(w_hit | (r_match_cnt != 4'd0));
            end
`else
            if (w_hit) begin
                r_match_cnt <= 4'd1;
            end else if (w_expire) begin
                r_timeout <= 1'b1;
            end
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_det_ctrl
// Brief    : Table-driven bench for seq_det_ctrl plus abort/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_det_ctrl_if #(.MAXL(8), .TW(8)) bus();
    seq_det_ctrl #(.MAXL(8), .TW(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [7:0]  pat;
        logic [2:0]  len;
        logic [7:0]  tmo;
        logic [31:0] stream;  // first bit fed is stream[nbits-1]
        int          nbits;
        int          dec;     // index of deciding bit (done the cycle after)
        logic        mt;
        logic        to;
        logic [7:0]  pos;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (case %0d): got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    task automatic chk_outputs(input string nm, input int id, input logic b, input logic d,
                               input logic m, input logic t, input logic [7:0] p, input logic [3:0] c);
        chk({nm, "_busy"}, id, 32'(bus.busy), 32'(b));
        chk({nm, "_done"}, id, 32'(bus.done), 32'(d));
        chk({nm, "_match"}, id, 32'(bus.match), 32'(m));
        chk({nm, "_timeout"}, id, 32'(bus.timeout), 32'(t));
        chk({nm, "_pos"}, id, 32'(bus.match_pos), 32'(p));
        chk({nm, "_cnt"}, id, 32'(bus.match_cnt), 32'(c));
    endtask

    task automatic run_session(input vec_t v, input int id);
        bit seen;
        seen = 1'b0;
        bus.cfg_pattern = v.pat;
        bus.cfg_len     = v.len;
        bus.cfg_timeout = v.tmo;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        chk("busy_after_start", id, 32'(bus.busy), 32'd1);
        // Scramble config: a latched design must not notice.
        bus.cfg_pattern = ~v.pat;
        bus.cfg_len     = ~v.len;
        bus.cfg_timeout = v.tmo + 8'd1;
        for (int i = 0; i < v.nbits && !seen; i++) begin
            bus.seq_in    = v.stream[v.nbits-1-i];
            bus.seq_valid = 1'b1;
            step();
            bus.seq_valid = 1'b0;
            chk("done_timing", id, 32'(bus.done), 32'(i + 1 == v.dec));
            if (bus.done) seen = 1'b1;
        end
        chk_outputs("result", id, seen, seen, v.mt, v.to, v.pos, v.cnt);
        if (!seen) begin
            bus.abort = 1'b1;
            step();
            bus.abort = 1'b0;
        end else begin
            step();
            chk_outputs("after_done", id, 1'b0, 1'b0, v.mt, v.to, v.pos, v.cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_timeout = '0;
        bus.seq_in      = 1'b0;
        bus.seq_valid   = 1'b0;

`ifdef SEQ_DET_CTRL_CONT_EN
        tbl.push_back(vec_t'{8'h03, 3'd1, 8'd6,  32'h0003F, 6,  6,  1'b1, 1'b0, 8'd2, 4'd5});
        tbl.push_back(vec_t'{8'h01, 3'd0, 8'd3,  32'h00000, 3,  3,  1'b0, 1'b1, 8'd0, 4'd0});
        tbl.push_back(vec_t'{8'h01, 3'd0, 8'd18, 32'h3FFFF, 18, 18, 1'b1, 1'b0, 8'd1, 4'd15});
        tbl.push_back(vec_t'{8'h05, 3'd2, 8'd5,  32'h00015, 5,  5,  1'b1, 1'b0, 8'd3, 4'd2});
`else
        tbl.push_back(vec_t'{8'h07, 3'd2, 8'd0,  32'h00007, 4,  4,  1'b1, 1'b0, 8'd4,  4'd1});
        tbl.push_back(vec_t'{8'hFF, 3'd7, 8'd8,  32'h000FE, 8,  8,  1'b0, 1'b1, 8'd0,  4'd0});
        tbl.push_back(vec_t'{8'h05, 3'd2, 8'd3,  32'h00005, 3,  3,  1'b1, 1'b0, 8'd3,  4'd1});
        tbl.push_back(vec_t'{8'h01, 3'd0, 8'd0,  32'h00001, 3,  3,  1'b1, 1'b0, 8'd3,  4'd1});
        tbl.push_back(vec_t'{8'hA5, 3'd7, 8'd0,  32'h007A5, 11, 11, 1'b1, 1'b0, 8'd11, 4'd1});
        tbl.push_back(vec_t'{8'h01, 3'd0, 8'd1,  32'h00000, 1,  1,  1'b0, 1'b1, 8'd0,  4'd0});
        tbl.push_back(vec_t'{8'h01, 3'd0, 8'd1,  32'h00001, 1,  1,  1'b1, 1'b0, 8'd1,  4'd1});
        tbl.push_back(vec_t'{8'h00, 3'd3, 8'd0,  32'h00000, 4,  4,  1'b1, 1'b0, 8'd4,  4'd1});
        tbl.push_back(vec_t'{8'h06, 3'd3, 8'd10, 32'h0002C, 7,  6,  1'b1, 1'b0, 8'd6,  4'd1});
`endif

        // Asynchronous reset: outputs must clear without a clock edge.
        #1 rst = 1'b1;
        #1;
        chk_outputs("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        step();
        step();
        rst = 1'b0;

        foreach (tbl[k]) run_session(tbl[k], k + 1);

        // Results hold in IDLE, then reset clears them asynchronously.
        step();
        step();
        chk_outputs("hold_idle", 100, 1'b0, 1'b0, tbl[tbl.size()-1].mt, tbl[tbl.size()-1].to,
                    tbl[tbl.size()-1].pos, tbl[tbl.size()-1].cnt);
        #2 rst = 1'b1;
        #1;
        chk_outputs("reset_idle", 101, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        step();
        rst = 1'b0;

        // Abort on the completing bit, with seq_valid gaps beforehand.
        bus.cfg_pattern = 8'h03;
        bus.cfg_len     = 3'd1;
        bus.cfg_timeout = 8'd0;
        bus.start       = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.seq_in    = 1'b1;
        bus.seq_valid = 1'b1;
        step();
        bus.seq_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            step();
            chk("abort_gap_done", 200 + g, 32'(bus.done), 32'd0);
        end
        bus.seq_valid = 1'b1;
        bus.abort     = 1'b1;
        step();
        bus.seq_valid = 1'b0;
        bus.abort     = 1'b0;
        chk_outputs("abort", 210, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        step();
        chk("abort_no_done", 211, 32'(bus.done), 32'd0);

`ifndef SEQ_DET_CTRL_CONT_EN
        // Same stream without abort: gaps must not shift, hit lands on bit 2.
        bus.start = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.seq_valid = 1'b1;
        step();
        bus.seq_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            step();
            chk("gap_done", 300 + g, 32'(bus.done), 32'd0);
        end
        bus.seq_valid = 1'b1;
        step();
        bus.seq_valid = 1'b0;
        chk_outputs("gap_hit", 310, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 4'd1);
        step();
`endif

        // Reset mid-session, then a clean session.
        bus.cfg_pattern = 8'h07;
        bus.cfg_len     = 3'd2;
        bus.cfg_timeout = 8'd0;
        bus.start       = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.seq_in    = 1'b1;
        bus.seq_valid = 1'b1;
        step();
        step();
        bus.seq_valid = 1'b0;
        chk("pre_reset_busy", 400, 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_outputs("reset_run", 401, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        step();
        rst = 1'b0;
        step();
        chk("reset_no_done", 402, 32'(bus.done), 32'd0);
        run_session(tbl[0], 403);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
